// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and direction constants for the counter monitor.
package cnt_pkg;
    typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_e;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc_i and holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/cnt_monitor.sv
// cnt_monitor: checks an observed counter against its declared direction,
// locks after LOCK_LEN consecutive correct steps and flags errors/wraps once locked.
module cnt_monitor
    import cnt_pkg::*;
#(
    parameter int W        = 4,
    parameter int LOCK_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [W-1:0]     i_cnt,
    input  logic             i_mode,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_wrap,
    output logic [ERR_W-1:0] o_err_cnt
);
    state_e       state_q, state_d;
    logic [W-1:0] ref_q, ref_d, exp_cnt;
    logic [3:0]   run_q, run_d;
    logic         err_q, err_d, wrap_q, wrap_d, match, wrap_pt, down;

    always_comb begin
        down    = i_mode == DOWN;
        exp_cnt = down ? ref_q - 1'b1 : ref_q + 1'b1;
        wrap_pt = down ? ref_q == '0 : ref_q == '1;
        match   = i_cnt == exp_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ref_q   <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            run_q   <= run_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    // Every accepted sample becomes the new reference, matched or not.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        run_d   = run_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        if (i_valid) begin
            ref_d = i_cnt;
            case (state_q)
                EMPTY: begin
                    state_d = ACQ;
                    run_d   = '0;
                end
                ACQ: begin
                    run_d = match ? run_q + 4'd1 : '0;
                    if (match && run_q + 4'd1 == 4'(LOCK_LEN)) state_d = LOCKED;
                end
                LOCKED: begin
                    wrap_d = match && wrap_pt;
                    err_d  = !match;
                    if (!match) begin
                        state_d = ACQ;
                        run_d   = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        o_locked = state_q == LOCKED;
        o_err    = err_q;
        o_wrap   = wrap_q;
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .inc_i (err_d),
        .cnt_o (o_err_cnt)
    );
endmodule

// File: tb/tb_cnt_monitor.sv
// tb_cnt_monitor: directed and randomized stimulus against a behavioural model,
// driving an ERR_W=8 and an ERR_W=2 instance in parallel.
module tb_cnt_monitor;
    localparam int M = 16;
    localparam int LL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0, valid = 1'b0, mode = 1'b0;
    logic [3:0] cnt = '0;
    logic       lk_a, er_a, wr_a, lk_b, er_b, wr_b;
    logic [7:0] ec_a;
    logic [1:0] ec_b;

    int passed = 0, total = 0;
    int has_ref = 0, ref_v = 0, run = 0, locked = 0, errs = 0, e_err = 0, e_wrap = 0;

    always #5 clk = ~clk;

    cnt_monitor #(.W(4), .LOCK_LEN(LL), .ERR_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_cnt(cnt), .i_mode(mode),
        .o_locked(lk_a), .o_err(er_a), .o_wrap(wr_a), .o_err_cnt(ec_a)
    );
    cnt_monitor #(.W(4), .LOCK_LEN(LL), .ERR_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_cnt(cnt), .i_mode(mode),
        .o_locked(lk_b), .o_err(er_b), .o_wrap(wr_b), .o_err_cnt(ec_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    function automatic int nxt(input int m);
        return (ref_v + (m != 0 ? M - 1 : 1)) % M;
    endfunction

    task automatic step(input int r, input int v, input int c, input int m);
        rst = r[0]; valid = v[0]; cnt = 4'(c); mode = m[0];
        @(posedge clk);
        e_err = 0; e_wrap = 0;
        if (r != 0) begin
            has_ref = 0; ref_v = 0; run = 0; locked = 0; errs = 0;
        end else if (v != 0) begin
            if (has_ref == 0) begin
                has_ref = 1; run = 0;
            end else if (c == nxt(m)) begin
                if (locked != 0) e_wrap = int'((m == 0 && ref_v == M - 1) || (m != 0 && ref_v == 0));
                else begin
                    run++;
                    if (run == LL) locked = 1;
                end
            end else begin
                if (locked != 0) begin
                    e_err = 1; errs++; locked = 0;
                end
                run = 0;
            end
            ref_v = c;
        end
        #1;
        chk("locked", 32'(lk_a), 32'(locked));
        chk("err", 32'(er_a), 32'(e_err));
        chk("wrap", 32'(wr_a), 32'(e_wrap));
        chk("err_cnt8", 32'(ec_a), 32'(errs > 255 ? 255 : errs));
        chk("err_cnt2", 32'(ec_b), 32'(errs > 3 ? 3 : errs));
        chk("err2", 32'(er_b), 32'(e_err));
        chk("err_wrap_excl", 32'(er_a & wr_a), 32'd0);
    endtask

    initial begin
        // Reset and up-count lock: 0,1,2,3
        step(1, 0, 0, 0);
        chk("reset_locked", 32'(lk_a), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, i, 0);
        chk("up_lock", 32'(lk_a), 32'd1);
        // Locked up wrap 14,15,0
        step(1, 0, 0, 0);
        for (int i = 11; i <= 15; i++) step(0, 1, i, 0);
        step(0, 1, 0, 0);
        chk("wrap_at_0", 32'(wr_a), 32'd1);
        step(0, 1, 1, 0);
        chk("wrap_once", 32'(wr_a), 32'd0);
        // Locked down-count with a stuck value, then relock
        step(1, 0, 0, 0);
        for (int i = 8; i >= 4; i--) step(0, 1, i, 1);
        step(0, 1, 4, 1);
        chk("down_err", 32'(er_a), 32'd1);
        chk("down_unlock", 32'(lk_a), 32'd0);
        for (int i = 3; i >= 1; i--) step(0, 1, i, 1);
        chk("down_relock", 32'(lk_a), 32'd1);
        // Idle gap while locked
        for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(15), $urandom_range(1));
        step(0, 1, 0, 1);
        chk("idle_locked", 32'(lk_a), 32'd1);
        chk("idle_no_err", 32'(er_a), 32'd0);
        // Five lock/mismatch cycles: 2-bit counter saturates, o_err keeps pulsing
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, (ref_v + 5) % M, 0);
            chk("sat_err_pulse", 32'(er_b), 32'd1);
            for (int i = 0; i < LL; i++) step(0, 1, nxt(0), 0);
        end
        chk("sat_cnt2", 32'(ec_b), 32'd3);
        chk("sat_cnt8", 32'(ec_a), 32'd5);
        // Reset while locked with two errors recorded, valid high on the same edge
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 1, (ref_v + 7) % M, 0);
            for (int i = 0; i < LL; i++) step(0, 1, nxt(0), 0);
        end
        chk("pre_rst_cnt", 32'(ec_a), 32'd2);
        step(1, 1, nxt(0), 0);
        chk("rst_locked", 32'(lk_a), 32'd0);
        chk("rst_cnt", 32'(ec_a), 32'd0);
        step(0, 1, 9, 0);
        chk("rst_empty", 32'(lk_a), 32'd0);
        // Randomized traffic biased toward correct steps
        for (int n = 0; n < 600; n++) begin
            int m, v, c;
            m = ($urandom_range(15) == 0) ? int'(!mode) : int'(mode);
            v = ($urandom_range(3) != 0) ? 1 : 0;
            c = ($urandom_range(7) != 0) ? nxt(m) : int'($urandom_range(15));
            step(($urandom_range(80) == 0) ? 1 : 0, v, c, m);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
